// File: rtl/pattern_vg_multi.sv
// Multi-mode video test-pattern generator: solid, colour bars, grid, ramp, checker.
// Define PATTERN_ANIM_EN to make the ramp scroll and the checker phase flip with frame count.
`timescale 1ns/1ps
module pattern_vg_multi #(
  parameter int COLOR_DEPTH = 8,
  parameter int X_BITS      = 13,
  parameter int Y_BITS      = 13,
  parameter int GRID_SHIFT  = 5
) (
  input  logic                     pix_clk,
  input  logic                     rstn,
  input  logic                     vs_in,
  input  logic                     hs_in,
  input  logic                     de_in,
  input  logic [2:0]               mode_in,
  input  logic [3*COLOR_DEPTH-1:0] solid_rgb,
  input  logic [11:0]              H_ACT,
  input  logic [11:0]              V_ACT,
  output logic                     vs_out,
  output logic                     hs_out,
  output logic                     de_out,
  output logic [COLOR_DEPTH-1:0]   r_out,
  output logic [COLOR_DEPTH-1:0]   g_out,
  output logic [COLOR_DEPTH-1:0]   b_out,
  output logic                     frame_start
);
  localparam int CW = 3*COLOR_DEPTH;
  localparam logic [COLOR_DEPTH-1:0] FULL = {COLOR_DEPTH{1'b1}};
  localparam logic [COLOR_DEPTH-1:0] MID  = {1'b1, {(COLOR_DEPTH-1){1'b0}}};

  logic              vs_d1, hs_d1, de_d1, vs_arm, bnd_d1;
  logic [X_BITS-1:0] x;
  logic [Y_BITS-1:0] y;
  logic [8:0]        bar_cnt;
  logic [2:0]        bar_idx;
  logic [2:0]        sh_mode;
  logic [CW-1:0]     sh_rgb;
  logic [11:0]       sh_h, sh_v;
  logic [7:0]        frame_cnt;

  // vs_arm blocks a vs_in that is already high at reset release from counting as an edge
  logic vs_rise, de_rise, de_fall;
  logic [8:0] bar_w;
  assign vs_rise = vs_in & ~vs_d1 & vs_arm;
  assign de_rise = de_in & ~de_d1;
  assign de_fall = ~de_in & de_d1;
  assign bar_w   = sh_h[11:3];

  // stage 1: sync/edge registers, shadows, position counters
  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      vs_d1 <= 1'b0; hs_d1 <= 1'b0; de_d1 <= 1'b0; vs_arm <= 1'b0; bnd_d1 <= 1'b0;
      x <= '0; y <= '0; bar_cnt <= '0; bar_idx <= '0;
      sh_mode <= '0; sh_rgb <= '0; sh_h <= '0; sh_v <= '0; frame_cnt <= '0;
    end else begin
      vs_d1  <= vs_in;
      hs_d1  <= hs_in;
      de_d1  <= de_in;
      vs_arm <= 1'b1;
      bnd_d1 <= vs_rise;
      if (vs_rise) begin
        sh_mode   <= mode_in;
        sh_rgb    <= solid_rgb;
        sh_h      <= H_ACT;
        sh_v      <= V_ACT;
        frame_cnt <= frame_cnt + 8'd1;
      end
      if (de_in) begin
        if (de_rise) begin
          x       <= '0;
          bar_cnt <= '0;
          bar_idx <= (bar_w == 9'd0) ? 3'd7 : 3'd0;
        end else begin
          x <= x + 1'b1;
          if (bar_w == 9'd0) begin
            bar_idx <= 3'd7;
          end else if (bar_cnt == bar_w - 9'd1) begin
            bar_cnt <= '0;
            if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
          end else begin
            bar_cnt <= bar_cnt + 9'd1;
          end
        end
      end else if (de_fall) begin
        x       <= '0;
        bar_cnt <= '0;
        bar_idx <= '0;
      end
      if (vs_rise)                  y <= '0;
      else if (de_fall && y != '1)  y <= y + 1'b1;
    end
  end

  logic [X_BITS-1:0]      x_last;
  logic [Y_BITS-1:0]      y_last;
  logic [COLOR_DEPTH-1:0] ofs, ramp;
  logic                   chk_ph;
  assign x_last = X_BITS'(sh_h) - X_BITS'(1);
  assign y_last = Y_BITS'(sh_v) - Y_BITS'(1);
`ifdef PATTERN_ANIM_EN
  assign ofs    = COLOR_DEPTH'(frame_cnt);
  assign chk_ph = frame_cnt[5];
`else
  assign ofs    = '0;
  assign chk_ph = 1'b0;
`endif
  assign ramp = x[COLOR_DEPTH-1:0] + ofs;

  logic [CW-1:0] pix;
  always_comb begin
    pix = '0;
    case (sh_mode)
      3'd0: pix = sh_rgb;
      // bar order white..black maps onto inverted index bits per channel
      3'd1: pix = {{COLOR_DEPTH{~bar_idx[1]}}, {COLOR_DEPTH{~bar_idx[2]}},
                   {COLOR_DEPTH{~bar_idx[0]}}};
      3'd2: pix = (x[GRID_SHIFT-1:0] == '0 || y[GRID_SHIFT-1:0] == '0 ||
                   x == x_last || y == y_last) ? {3{FULL}} : '0;
      3'd3: pix = {ramp, ramp, ramp};
      3'd4: pix = (x[GRID_SHIFT] ^ y[GRID_SHIFT] ^ chk_ph) ? {3{FULL}} : '0;
      default: pix = {MID, MID, MID};
    endcase
  end

  // stage 2: colour and delayed syncs
  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      vs_out <= 1'b0; hs_out <= 1'b0; de_out <= 1'b0; frame_start <= 1'b0;
      r_out <= '0; g_out <= '0; b_out <= '0;
    end else begin
      vs_out      <= vs_d1;
      hs_out      <= hs_d1;
      de_out      <= de_d1;
      frame_start <= bnd_d1;
      {r_out, g_out, b_out} <= de_d1 ? pix : '0;
    end
  end
endmodule

// File: tb/tb_pattern_vg_multi.sv
// Bench for pattern_vg_multi: frame-level behavioural model checked every cycle plus literal probes.
`timescale 1ns/1ps
module tb_pattern_vg_multi;
  logic        pix_clk = 1'b0, rstn = 1'b0, vs_in = 1'b0, hs_in = 1'b0, de_in = 1'b0;
  logic [2:0]  mode_in = '0;
  logic [23:0] solid_rgb = '0;
  logic [11:0] H_ACT = '0, V_ACT = '0;
  logic        vs_out, hs_out, de_out, frame_start;
  logic [7:0]  r_out, g_out, b_out;

  always #5 pix_clk = ~pix_clk;

  pattern_vg_multi dut (
    .pix_clk(pix_clk), .rstn(rstn), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
    .mode_in(mode_in), .solid_rgb(solid_rgb), .H_ACT(H_ACT), .V_ACT(V_ACT),
    .vs_out(vs_out), .hs_out(hs_out), .de_out(de_out),
    .r_out(r_out), .g_out(g_out), .b_out(b_out), .frame_start(frame_start));

  typedef struct packed {
    logic vs, hs, de, fs;
    logic [23:0] rgb;
    logic [12:0] x, y;
    logic [3:0]  ph;
  } exp_t;

  int total = 0, bad = 0, phase = 0, fs_cnt = 0, np = 0;
  bit run = 1'b1;
  exp_t p1 = '0, p2 = '0;

  // model state: frame-level view of what the generator should be showing
  bit prev_vs, vs_valid, prev_de;
  int sh_mode, sh_h, sh_v, fcnt, px, py;
  logic [23:0] sh_rgb;

  int pr_ph[32], pr_x[32], pr_y[32];
  logic [23:0] pr_rgb[32];
  bit pr_hit[32];

  function automatic logic [23:0] model_rgb(int x, int y);
    int bw, bi, ofs, ph;
    logic [7:0] v;
    ofs = 0; ph = 0;
`ifdef PATTERN_ANIM_EN
    ofs = fcnt;
    ph  = (fcnt / 32) % 2;
`endif
    case (sh_mode)
      0: return sh_rgb;
      1: begin
        bw = sh_h / 8;
        bi = (bw == 0) ? 7 : ((x / bw > 7) ? 7 : x / bw);
        case (bi)
          0: return 24'hFFFFFF; 1: return 24'hFFFF00; 2: return 24'h00FFFF;
          3: return 24'h00FF00; 4: return 24'hFF00FF; 5: return 24'hFF0000;
          6: return 24'h0000FF; default: return 24'h000000;
        endcase
      end
      2: return (x % 32 == 0 || y % 32 == 0 || x == sh_h - 1 || y == sh_v - 1) ? 24'hFFFFFF : 24'h0;
      3: begin v = 8'((x + ofs) % 256); return {v, v, v}; end
      4: return ((((x / 32) % 2) ^ ((y / 32) % 2) ^ ph) != 0) ? 24'hFFFFFF : 24'h0;
      default: return 24'h808080;
    endcase
  endfunction

  initial forever begin
    exp_t e;
    bit bnd;
    @(posedge pix_clk or negedge rstn);
    if (!rstn) begin
      prev_vs = 0; vs_valid = 0; prev_de = 0;
      sh_mode = 0; sh_h = 0; sh_v = 0; fcnt = 0; px = 0; py = 0; sh_rgb = '0;
      p1 = '0; p2 = '0;
    end else begin
      e = '0;
      bnd = vs_valid && vs_in && !prev_vs;
      if (bnd) begin
        sh_mode = int'(mode_in); sh_rgb = solid_rgb; sh_h = int'(H_ACT); sh_v = int'(V_ACT);
        fcnt = (fcnt + 1) % 256; py = 0;
      end
      if (de_in) px = prev_de ? (px + 1) % 8192 : 0;
      e.vs = vs_in; e.hs = hs_in; e.de = de_in; e.fs = bnd;
      e.rgb = de_in ? model_rgb(px, py) : 24'h0;
      e.x = 13'(px); e.y = 13'(py); e.ph = 4'(phase);
      if (!de_in && prev_de) begin
        px = 0;
        if (py < 8191) py = py + 1;
      end
      prev_vs = vs_in; vs_valid = 1; prev_de = de_in;
      p2 = p1; p1 = e;
    end
  end

  initial forever begin
    logic [27:0] act, want;
    @(negedge pix_clk);
    if (run) begin
      act  = {vs_out, hs_out, de_out, frame_start, r_out, g_out, b_out};
      want = {p2.vs, p2.hs, p2.de, p2.fs, p2.rgb};
      total++;
      if (act !== want) begin
        bad++;
        if (bad < 20) $display("FAIL cycle t=%0t {vs,hs,de,fs,rgb} got %h want %h", $time, act, want);
      end
      if (p2.de)
        for (int i = 0; i < np; i++)
          if (pr_ph[i] == int'(p2.ph) && pr_x[i] == int'(p2.x) && pr_y[i] == int'(p2.y)) begin
            pr_hit[i] = 1;
            total++;
            if ({r_out, g_out, b_out} !== pr_rgb[i]) begin
              bad++;
              $display("FAIL probe%0d ph%0d (%0d,%0d) got %h want %h", i, pr_ph[i], pr_x[i], pr_y[i],
                       {r_out, g_out, b_out}, pr_rgb[i]);
            end
          end
      if (phase == 7 && frame_start === 1'b1) fs_cnt++;
    end
  end

  task automatic addp(int ph, int x, int y, logic [23:0] c);
    pr_ph[np] = ph; pr_x[np] = x; pr_y[np] = y; pr_rgb[np] = c; pr_hit[np] = 0; np++;
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic tick;
    @(posedge pix_clk); #1;
  endtask

  task automatic line(int n);
    de_in = 1; repeat (n) tick;
    de_in = 0; hs_in = 1; tick;
    hs_in = 0; tick;
  endtask

  task automatic vsync;
    vs_in = 1; tick; tick;
    vs_in = 0; tick; tick;
  endtask

  initial begin
    addp(0, 5, 0, 24'h000000);
    addp(1, 0, 0, 24'hFFFFFF);    addp(1, 159, 0, 24'hFFFFFF); addp(1, 160, 0, 24'hFFFF00);
    addp(1, 640, 0, 24'hFF00FF);  addp(1, 1279, 0, 24'h000000);
    addp(2, 1119, 0, 24'h0000FF); addp(2, 1120, 0, 24'h000000); addp(2, 1284, 0, 24'h000000);
    addp(3, 33, 0, 24'hFFFFFF);   addp(3, 32, 5, 24'hFFFFFF);   addp(3, 33, 5, 24'h000000);
    addp(3, 1279, 5, 24'hFFFFFF); addp(3, 33, 719, 24'hFFFFFF);
    addp(4, 0, 0, 24'h123456);    addp(4, 35, 1, 24'h123456);
    addp(5, 0, 0, 24'h000000);    addp(5, 32, 0, 24'hFFFFFF);
    addp(6, 3, 0, 24'h000000);
`ifdef PATTERN_ANIM_EN
    addp(9, 0, 0, 24'h030303);    addp(9, 255, 0, 24'h020202);
`else
    addp(9, 0, 0, 24'h000000);    addp(9, 255, 0, 24'hFFFFFF);
`endif

    // reset with vs_in held high: release must not count as a frame boundary
    vs_in = 1;
    repeat (3) tick;
    chk("reset_outputs", {4'h0, vs_out, hs_out, de_out, frame_start, r_out, g_out, b_out}, 32'h0);
    rstn = 1; tick; tick;
    vs_in = 0; tick;
    mode_in = 3'd3; H_ACT = 12'd1280; V_ACT = 12'd720;
    line(10);

    phase = 1; mode_in = 3'd1; vsync; line(1280);
    phase = 2; H_ACT = 12'd1285; vsync; line(1285);

    phase = 3; H_ACT = 12'd1280; mode_in = 3'd2; vsync;
    line(40); repeat (4) line(2); line(1280); repeat (713) line(2); line(40);

    phase = 4; mode_in = 3'd0; solid_rgb = 24'h123456; vsync;
    line(40); mode_in = 3'd4; line(40);
    phase = 5; vsync; line(40);

    de_in = 1; repeat (20) tick;
    phase = 6; rstn = 0; #1;
    chk("midline_reset_outputs", {4'h0, vs_out, hs_out, de_out, frame_start, r_out, g_out, b_out}, 32'h0);
    tick; tick; tick;
    rstn = 1;
    repeat (10) tick;
    de_in = 0; tick; tick;

    phase = 7; mode_in = 3'd3; H_ACT = 12'd1280; vsync; line(260);
    chk("frame_start_pulses", 32'(fs_cnt), 32'd1);
    phase = 8; vsync; line(260);
    phase = 9; vsync; line(260);
    repeat (3) tick;
    run = 0;

    for (int i = 0; i < np; i++)
      if (!pr_hit[i]) begin
        total++; bad++;
        $display("FAIL probe%0d not reached got none want ph%0d (%0d,%0d)", i, pr_ph[i], pr_x[i], pr_y[i]);
      end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pattern_vg_multi.md
# pattern_vg_multi

Multi-mode video test-pattern generator, the parametrised successor of the fixed-colour pattern stage in the HDMI output path. Sits between the video timing generator and the HDMI encoder. It tracks pixel position internally from `de_in`/`vs_in` and produces one of five selectable patterns. Mode, solid colour and active size are shadowed per frame, so changes never tear mid-frame.

## Interface
Parameters:
- `COLOR_DEPTH`, 8: bits per colour channel.
- `X_BITS`, 13: width of the internal column counter.
- `Y_BITS`, 13: width of the internal row counter.
- `GRID_SHIFT`, 5: grid and checker pitch is 2^GRID_SHIFT pixels (default 32).

Ports:
- `pix_clk` in 1: pixel clock; the only clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `vs_in` in 1: vertical sync, active-high. Its rising edge marks the frame boundary.
- `hs_in` in 1: horizontal sync, passed through.
- `de_in` in 1: data enable; high for active pixels.
- `mode_in` in 3: pattern select, sampled at the frame boundary.
- `solid_rgb` in 3*COLOR_DEPTH: packed {R,G,B} for mode 0, sampled at the frame boundary.
- `H_ACT` in 12: active pixels per line, sampled at the frame boundary.
- `V_ACT` in 12: active lines per frame, sampled at the frame boundary.
- `vs_out`, `hs_out`, `de_out` out 1 each: syncs delayed to align with pixel data.
- `r_out`, `g_out`, `b_out` out COLOR_DEPTH each: pixel data.
- `frame_start` out 1: one-cycle pulse, aligned with the `vs_out` rising edge.

## Operation
- Frame boundary: a registered `vs_in` rising edge. At this edge the block:
  - latches `mode_in`, `solid_rgb`, `H_ACT` and `V_ACT` into shadow registers;
  - clears the row counter `y`;
  - increments `frame_cnt` (8 bits, wraps 255->0).
- Column counter `x`:
  - 0 on the first `de_in`-high cycle of a line;
  - increments each `de_in`-high cycle and wraps at 2^X_BITS;
  - clears on the `de_in` falling edge.
- Row counter `y`: increments on each `de_in` falling edge and saturates at all-ones.
- Bar tracker (no divider or multiplier):
  - `bar_w` = shadow `H_ACT` >> 3;
  - `bar_cnt` counts 0..`bar_w`-1; on reaching `bar_w`-1 it clears and `bar_idx` increments;
  - `bar_idx` saturates at 7, so any remainder pixels belong to bar 7;
  - `bar_cnt` and `bar_idx` clear on the `de_in` falling edge;
  - if `bar_w`=0 (`H_ACT` < 8), `bar_idx` is held at 7.
- FULL = all-ones; ZERO = 0; MID = MSB set, rest 0.
- Patterns by shadow mode:
  - 0 solid: `solid_rgb`.
  - 1 colour bars: bar_idx 0..7 = white, yellow, cyan, green, magenta, red, blue, black (FULL/ZERO per channel).
  - 2 grid:
    - white when `x[GRID_SHIFT-1:0]`==0, `y[GRID_SHIFT-1:0]`==0, `x`==`H_ACT`-1 or `y`==`V_ACT`-1;
    - black otherwise.
  - 3 ramp: R=G=B=(`x` + offset)[COLOR_DEPTH-1:0]; offset per Configuration.
  - 4 checker: all channels FULL when `x[GRID_SHIFT]`^`y[GRID_SHIFT]` is set, else ZERO.
  - 5-7 reserved: all channels MID.
- `de` low: R/G/B forced to ZERO regardless of mode.
- Pixels beyond shadow `H_ACT`/`V_ACT` while `de_in` is high: pattern continues per the rules above; no extra masking.

## Timing
- Two-stage pipeline.
  - Stage 1 registers syncs, `x`, `y`, `bar_idx`, and the edge-detect of `de_in`/`vs_in`.
  - Stage 2 registers colour and the delayed syncs.
- Latency from every input (`vs_in`, `hs_in`, `de_in`) to the corresponding output is 2 cycles. Syncs and RGB stay exactly aligned.
- `frame_start` asserts in the same cycle that `vs_out` rises, for 1 cycle.
- Shadow registers update on the frame-boundary cycle. A new mode is visible from the first active pixel of that frame. Input changes mid-frame have no effect until the next `vs_in` rising edge.
- Reset (`rstn` low, asynchronous):
  - all outputs, counters, `frame_cnt`, shadow mode and shadow `solid_rgb` go to 0;
  - shadow `H_ACT` and `V_ACT` go to 0;
  - after release, output is black solid until the first frame boundary.
- Reset mid-frame: output is 0 immediately; counters resynchronise on the next `de_in` rising edge for `x` and the next `vs_in` rising edge for `y`.
- `vs_in` high at reset release is not a rising edge. The first boundary is the next 0->1 transition.

## Configuration
- `PATTERN_ANIM_EN` defined:
  - ramp offset = `frame_cnt`, so the ramp scrolls by 1 code per frame;
  - checker phase inverts when `frame_cnt[5]` is set (period 64 frames).
- `PATTERN_ANIM_EN` undefined:
  - offset = 0 and checker phase is fixed;
  - `frame_cnt` is still maintained and used only internally;
  - static images.

## Test plan
- Bars: `H_ACT`=1280, mode 1.
  - x=159 -> FFFFFF;
  - x=160 -> FFFF00;
  - x=1279 -> 000000;
  - `de_out` follows `de_in` by exactly 2 cycles.
- Bars with remainder: `H_ACT`=1285, mode 1.
  - x=1119 -> 0000FF (blue);
  - x=1120 through 1284 -> 000000 (bar 7).
- Grid: 1280x720, mode 2, GRID_SHIFT=5.
  - (32,5) white; (33,5) black; (1279,5) white; (33,719) white; (33,0) white.
- Mode latch: switch `mode_in` 0->4 mid-frame with `solid_rgb`=123456.
  - Rest of the frame stays 123456.
  - Next frame at (0,0) -> 000000 and at (32,0) -> FFFFFF.
- Animation with `PATTERN_ANIM_EN`, mode 3: on the 3rd frame after reset, x=0 -> 030303 and x=255 -> 020202. Without the macro, x=0 -> 000000.
- Reset mid-line: pulse `rstn` low for 3 cycles during `de_in` high.
  - All outputs 0 within the reset.
  - Shadow mode is 0 after release, so output is black until the next `vs_in` rising edge.
  - `frame_start` pulses once at that edge.
